// File: rtl/compressor_mult_sequencer.sv
// Iterative unsigned multiplier: one shared row of 4:2 compressors folds two
// partial products per cycle into a carry-save pair, then one carry-propagate
// add resolves the product. Handshake is start/busy/done.
module compressor_mult_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned STEPS  = WIDTH / 2;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    RESOLVE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [PW-1:0]       s_q;
  logic [PW-1:0]       c_q;
  logic [STEP_W-1:0]   step_q;
  logic                busy_q;
  logic                done_q;
  logic [PW-1:0]       product_q;

  logic [STEP_W:0]     idx0;
  logic [STEP_W:0]     idx1;
  logic [PW-1:0]       pp0;
  logic [PW-1:0]       pp1;
  logic [PW-1:0]       s_d;
  logic [PW-1:0]       carry;
  logic [PW-1:0]       c_d;

  // Partial products for the current step: multiplier bits 2j and 2j+1.
  always_comb begin
    idx0 = {step_q, 1'b0};
    idx1 = {step_q, 1'b1};
    pp0  = b_q[idx0] ? (PW'(a_q) << idx0) : '0;
    pp1  = b_q[idx1] ? (PW'(a_q) << idx1) : '0;
  end

  // Compressor row: each 4:2 cell passes its inner carry to the next bit.
  always_comb begin
    logic t;
    logic cin_v;
    logic x1, x2, x3, x4;
    s_d   = '0;
    carry = '0;
    cin_v = 1'b0;
    for (int i = 0; i < PW; i++) begin
      x1       = s_q[i];
      x2       = c_q[i];
      x3       = pp0[i];
      x4       = pp1[i];
      t        = x1 ^ x2 ^ x3;
      s_d[i]   = t ^ x4 ^ cin_v;
      carry[i] = (t & x4) | (t & cin_v) | (x4 & cin_v);
      cin_v    = (x1 & x2) | (x1 & x3) | (x2 & x3);
    end
    c_d = carry << 1;
  end

  // Sequencer: latches operands, steps the compressor row, resolves the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= '0;
            c_q     <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= COMPRESS;
          end
        end
        COMPRESS: begin
          s_q    <= s_d;
          c_q    <= c_d;
          step_q <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(STEPS - 1)) begin
            state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          product_q <= s_q + c_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_compressor_mult_sequencer.sv
// Scoreboard bench for compressor_mult_sequencer: stimulus pushes expected
// products and acceptance cycles, a negedge monitor pops on every done.
module tb_compressor_mult_sequencer;

  localparam int W   = 8;
  localparam int PW  = 2 * W;
  localparam int LAT = W / 2 + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  typedef struct {
    logic [PW-1:0] p;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [PW-1:0] held = '0;
  logic          prev_done = 1'b0;

  compressor_mult_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
    $fatal(1);
  end

  // Monitor: checks every done against the scoreboard and product stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: done high on consecutive cycles at cycle %0d, required single pulse", cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_done: got busy=%b required 0", busy);
        end
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done at cycle %0d with product %0d, none expected", cyc, product);
        end else begin
          e = q.pop_front();
          checks++;
          if (product !== e.p) begin
            errors++;
            $display("FAIL product: got %0d required %0d", product, e.p);
          end
          checks++;
          if (cyc != e.acc + LAT) begin
            errors++;
            $display("FAIL latency: done at cycle %0d required %0d", cyc, e.acc + LAT);
          end
        end
        held = product;
      end else begin
        checks++;
        if (product !== held) begin
          errors++;
          $display("FAIL product_hold: got %0d required %0d at cycle %0d", product, held, cyc);
        end
      end
      prev_done = done;
    end
  end

  // Issue one multiply as soon as the block is idle; push expectation on acceptance.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [PW-1:0] exp_p);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=%b after %0d cycles required 0", busy, n);
    end
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.p = exp_p;
    e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got busy=%b required 1", busy);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b product=%0d required 0/0/0", tag, busy, done, product);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;

    // Directed products.
    do_op(8'd13, 8'd11, 16'd143);
    do_op(8'd255, 8'd255, 16'd65025);
    do_op(8'd0, 8'd200, 16'd0);

    // start raised mid-operation with new operands must be ignored.
    do_op(8'd7, 8'd9, 16'd63);
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;

    // Asynchronous reset mid-operation aborts with no done.
    do_op(8'd100, 8'd50, 16'd5000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    held = '0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    do_op(8'd2, 8'd3, 16'd6);

    // Back-to-back: second start lands in the done cycle of the first.
    do_op(8'd5, 8'd6, 16'd30);
    do_op(8'd12, 8'd12, 16'd144);

    // Random sweep with idle gaps of 0-3 cycles.
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, PW'(ra) * PW'(rb));
    end

    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results required 0", q.size());
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
